// File: rtl/exe_stage_if.sv
// Execute-stage operand/result bundle. The flag signals exist only when EXE_FLAGS_EN is defined.
interface exe_stage_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] ImmExtend;
  logic [WIDTH-1:0] Data2;
  logic [WIDTH-1:0] Data1;
  logic [2:0]       ALUSignal;
  logic             OpbSelect;
  logic             in_valid;
  logic [WIDTH-1:0] ALUResult;
  logic             out_valid;
`ifdef EXE_FLAGS_EN
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
`endif

  modport master (
    output ImmExtend, Data2, Data1, ALUSignal, OpbSelect, in_valid,
`ifdef EXE_FLAGS_EN
    input  zero, negative, carry, overflow,
`endif
    input  ALUResult, out_valid
  );

  modport slave (
    input  ImmExtend, Data2, Data1, ALUSignal, OpbSelect, in_valid,
`ifdef EXE_FLAGS_EN
    output zero, negative, carry, overflow,
`endif
    output ALUResult, out_valid
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: operand-B select, 8-op ALU, one-cycle registered result.
// Optional registered status flags when EXE_FLAGS_EN is defined.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [4:0]       w_shamt;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_slt;
  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] r_result;
  logic             r_valid;

  assign w_opa   = bus.Data1;
  assign w_opb   = bus.OpbSelect ? bus.ImmExtend : bus.Data2;
  assign w_shamt = w_opb[4:0];
  assign w_slt   = ($signed(w_opa) < $signed(w_opb));

`ifdef EXE_FLAGS_EN
  // Widened add/sub expose carry-out and borrow for the flags.
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;
  logic           w_carry;
  logic           w_overflow;
  logic           r_zero;
  logic           r_negative;
  logic           r_carry;
  logic           r_overflow;

  assign w_sum  = {1'b0, w_opa} + {1'b0, w_opb};
  assign w_diff = {1'b0, w_opa} - {1'b0, w_opb};
  assign w_add  = w_sum[WIDTH-1:0];
  assign w_sub  = w_diff[WIDTH-1:0];
`else
  assign w_add  = w_opa + w_opb;
  assign w_sub  = w_opa - w_opb;
`endif

  always_comb begin
    w_result = '0;
    case (bus.ALUSignal)
      OP_ADD:  w_result = w_add;
      OP_SUB:  w_result = w_sub;
      OP_AND:  w_result = w_opa & w_opb;
      OP_OR:   w_result = w_opa | w_opb;
      OP_XOR:  w_result = w_opa ^ w_opb;
      OP_SLL:  w_result = w_opa << w_shamt;
      OP_SRL:  w_result = w_opa >> w_shamt;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_result <= w_result;
      end else begin
        r_result <= r_result;
      end
    end
  end

  assign bus.ALUResult = r_result;
  assign bus.out_valid = r_valid;

`ifdef EXE_FLAGS_EN
  // Carry on SUB is not-borrow, i.e. A >= B unsigned.
  always_comb begin
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    case (bus.ALUSignal)
      OP_ADD: begin
        w_carry    = w_sum[WIDTH];
        w_overflow = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) && (w_add[WIDTH-1] != w_opa[WIDTH-1]);
      end
      OP_SUB: begin
        w_carry    = ~w_diff[WIDTH];
        w_overflow = (w_opa[WIDTH-1] != w_opb[WIDTH-1]) && (w_sub[WIDTH-1] != w_opa[WIDTH-1]);
      end
      default: begin
        w_carry    = 1'b0;
        w_overflow = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (bus.in_valid) begin
      r_zero     <= (w_result == '0);
      r_negative <= w_result[WIDTH-1];
      r_carry    <= w_carry;
      r_overflow <= w_overflow;
    end else begin
      r_zero     <= r_zero;
      r_negative <= r_negative;
      r_carry    <= r_carry;
      r_overflow <= r_overflow;
    end
  end

  assign bus.zero     = r_zero;
  assign bus.negative = r_negative;
  assign bus.carry    = r_carry;
  assign bus.overflow = r_overflow;
`endif
endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: arithmetic reference model, per-cycle compare, directed literals.
module tb_exe_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  exe_stage_if #(.WIDTH(32)) bus ();
  exe_stage #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] m_res   = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_zero = 1'b0, m_neg = 1'b0, m_carry = 1'b0, m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return (sa < sb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Reference model: result/flags from plain arithmetic on the sampled inputs.
  always @(posedge clk or posedge rst) begin
    logic [31:0] a, b;
    longint ua, ub, ss;
    if (rst) begin
      m_res = 32'h0; m_valid = 1'b0;
      m_zero = 1'b0; m_neg = 1'b0; m_carry = 1'b0; m_ovf = 1'b0;
    end else begin
      m_valid = bus.in_valid;
      if (bus.in_valid) begin
        a  = bus.Data1;
        b  = bus.OpbSelect ? bus.ImmExtend : bus.Data2;
        ua = longint'(a);
        ub = longint'(b);
        m_res   = ref_alu(a, b, bus.ALUSignal);
        m_zero  = (m_res == 32'h0);
        m_neg   = m_res[31];
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        if (bus.ALUSignal == 3'd0) begin
          m_carry = (ua + ub) > 64'sd4294967295;
          ss = longint'($signed(a)) + longint'($signed(b));
          m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end else if (bus.ALUSignal == 3'd1) begin
          m_carry = (ua >= ub);
          ss = longint'($signed(a)) - longint'($signed(b));
          m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    check("ALUResult", bus.ALUResult, m_res);
`ifdef EXE_FLAGS_EN
    check("flags", {28'd0, bus.zero, bus.negative, bus.carry, bus.overflow},
          {28'd0, m_zero, m_neg, m_carry, m_ovf});
`endif
  end

  task automatic drive(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic sel, input logic [2:0] op, input logic v);
    @(negedge clk);
    bus.Data1 = d1; bus.Data2 = d2; bus.ImmExtend = imm;
    bus.OpbSelect = sel; bus.ALUSignal = op; bus.in_valid = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.Data1 = 32'h0; bus.Data2 = 32'h0; bus.ImmExtend = 32'h0;
    bus.OpbSelect = 1'b0; bus.ALUSignal = 3'd0; bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_result", bus.ALUResult, 32'h0);
    check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b0;

    drive(32'd0, 32'd8, 32'd8, 1'b1, 3'b000, 1'b1);
    check("imm_add", bus.ALUResult, 32'd8);
    check("imm_add_valid", {31'd0, bus.out_valid}, 32'd1);
    drive(32'd10, 32'd4, 32'd8, 1'b0, 3'b100, 1'b1);
    check("reg_xor", bus.ALUResult, 32'd14);
    drive(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b001, 1'b1);
    check("sub_neg", bus.ALUResult, 32'hFFFF_FFFE);
    drive(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b111, 1'b1);
    check("slt_signed", bus.ALUResult, 32'd1);
    drive(32'd5, 32'd5, 32'd0, 1'b0, 3'b001, 1'b1);
    check("sub_zero", bus.ALUResult, 32'd0);
`ifdef EXE_FLAGS_EN
    check("zero_flag", {31'd0, bus.zero}, 32'd1);
    check("sub_eq_carry", {31'd0, bus.carry}, 32'd1);
`endif
    drive(32'h8000_0001, 32'h21, 32'd0, 1'b0, 3'b101, 1'b1);
    check("sll", bus.ALUResult, 32'h0000_0002);
    drive(32'h8000_0001, 32'h21, 32'd0, 1'b0, 3'b110, 1'b1);
    check("srl", bus.ALUResult, 32'h4000_0000);
    drive(32'h1234_5678, 32'h9, 32'h3, 1'b1, 3'b000, 1'b0);
    drive(32'hDEAD_BEEF, 32'h1, 32'h7, 1'b0, 3'b011, 1'b0);
    check("hold_result", bus.ALUResult, 32'h4000_0000);
    check("hold_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 3'b000, 1'b1);
    check("add_wrap", bus.ALUResult, 32'h8000_0000);
`ifdef EXE_FLAGS_EN
    check("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    check("neg_flag", {31'd0, bus.negative}, 32'd1);
`endif

    // Asynchronous reset mid-cycle after a valid op.
    drive(32'd3, 32'd4, 32'd0, 1'b0, 3'b000, 1'b1);
    check("pre_reset", bus.ALUResult, 32'd7);
    #2 rst = 1'b1;
    #1;
    check("async_rst_result", bus.ALUResult, 32'h0);
    check("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    drive(32'd9, 32'd9, 32'd0, 1'b0, 3'b000, 1'b1);
    check("rst_hold_result", bus.ALUResult, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_capture", bus.ALUResult, 32'd18);
    check("first_capture_valid", {31'd0, bus.out_valid}, 32'd1);

    for (int i = 0; i < 400; i++) begin
      drive(pick(), pick(), pick(), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
